// File: rtl/gp_decode_stage.sv
// Registered decode stage: turns 16-bit MAK-8 instructions into control and field outputs.
// Vector instructions are issued as VLANES per-lane micro-ops, one per cycle.
module gp_decode_stage #(
  parameter int DATA_W = 16,
  parameter int VLANES = 4,
  localparam int LANE_W = (VLANES > 1) ? $clog2(VLANES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [15:0]       in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_pc,
  output logic [3:0]        out_opcode,
  output logic [2:0]        out_rd,
  output logic [2:0]        out_rs1,
  output logic [2:0]        out_rs2,
  output logic [2:0]        out_func,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_reg_write,
  output logic              out_vector_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_branch,
  output logic              out_jump,
  output logic              out_alu_src_imm,
  output logic              out_is_vector,
  output logic [3:0]        out_alu_op,
  output logic [LANE_W-1:0] out_lane,
  output logic              out_last,
  output logic              out_illegal
);

  typedef enum logic {EMPTY, HOLD} state_t;

  typedef struct packed {
    logic [15:0]       pc;
    logic [3:0]        opcode;
    logic [2:0]        rd;
    logic [2:0]        rs1;
    logic [2:0]        rs2;
    logic [2:0]        func;
    logic [DATA_W-1:0] imm;
    logic              reg_write;
    logic              vector_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic              alu_src_imm;
    logic              is_vector;
    logic [3:0]        alu_op;
    logic              illegal;
  } uop_t;

  state_t            state;
  uop_t              dec;
  uop_t              uop;
  logic [LANE_W-1:0] lane;
  logic              last_lane;
  logic              accept;
  logic              advance;

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.opcode = in_instr[15:12];
    dec.rd     = in_instr[11:9];
    dec.rs1    = in_instr[8:6];
    dec.rs2    = in_instr[5:3];
    dec.func   = in_instr[2:0];
    case (in_instr[15:12])
      4'b0000: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = {1'b0, in_instr[2:0]};
      end
      4'b0001: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm         = {{(DATA_W-6){in_instr[5]}}, in_instr[5:0]};
      end
      4'b0111: begin
        dec.reg_write   = 1'b1;
        dec.mem_read    = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm         = {{(DATA_W-6){in_instr[5]}}, in_instr[5:0]};
      end
      4'b1000: begin
        dec.mem_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.imm         = {{(DATA_W-6){in_instr[5]}}, in_instr[5:0]};
      end
      4'b1001: begin
        dec.branch = 1'b1;
        dec.alu_op = 4'b0001;
        dec.imm    = {{(DATA_W-9){in_instr[8]}}, in_instr[8:0]};
      end
      4'b1010: begin
        dec.jump = 1'b1;
        dec.imm  = {{(DATA_W-12){in_instr[11]}}, in_instr[11:0]};
      end
      4'b1011: begin
        dec.is_vector    = 1'b1;
        dec.vector_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign last_lane = !uop.is_vector || (lane == LANE_W'(VLANES - 1));
  assign out_valid = (state == HOLD);
  assign out_last  = out_valid && last_lane;
  assign in_ready  = rst_n && !flush && ((state == EMPTY) || (out_ready && out_last));
  assign accept    = in_valid && in_ready;
  assign advance   = out_valid && out_ready;

  // Leaving HOLD clears the held micro-op so idle outputs read as zero, matching reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      uop   <= '0;
      lane  <= '0;
    end else if (flush) begin
      state <= EMPTY;
      uop   <= '0;
      lane  <= '0;
    end else if (accept) begin
      state <= HOLD;
      uop   <= dec;
      lane  <= '0;
    end else if (advance) begin
      if (last_lane) begin
        state <= EMPTY;
        uop   <= '0;
        lane  <= '0;
      end else begin
        lane <= lane + LANE_W'(1);
      end
    end
  end

  assign out_pc           = uop.pc;
  assign out_opcode       = uop.opcode;
  assign out_rd           = uop.rd;
  assign out_rs1          = uop.rs1;
  assign out_rs2          = uop.rs2;
  assign out_func         = uop.func;
  assign out_imm          = uop.imm;
  assign out_reg_write    = uop.reg_write;
  assign out_vector_write = uop.vector_write;
  assign out_mem_read     = uop.mem_read;
  assign out_mem_write    = uop.mem_write;
  assign out_branch       = uop.branch;
  assign out_jump         = uop.jump;
  assign out_alu_src_imm  = uop.alu_src_imm;
  assign out_is_vector    = uop.is_vector;
  assign out_alu_op       = uop.alu_op;
  assign out_illegal      = uop.illegal;
  assign out_lane         = lane;

endmodule

// File: tb/tb_gp_decode_stage.sv
// Bench for gp_decode_stage: vector table streamed through a scoreboard, plus stall/flush/reset sequences.
module tb_gp_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic [15:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_pc;
  logic [3:0]  out_opcode;
  logic [2:0]  out_rd, out_rs1, out_rs2, out_func;
  logic [15:0] out_imm;
  logic        out_reg_write, out_vector_write, out_mem_read, out_mem_write;
  logic        out_branch, out_jump, out_alu_src_imm, out_is_vector;
  logic [3:0]  out_alu_op;
  logic [1:0]  out_lane;
  logic        out_last;
  logic        out_illegal;

  gp_decode_stage #(.DATA_W(16), .VLANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_func(out_func), .out_imm(out_imm),
    .out_reg_write(out_reg_write), .out_vector_write(out_vector_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_branch(out_branch), .out_jump(out_jump), .out_alu_src_imm(out_alu_src_imm),
    .out_is_vector(out_is_vector), .out_alu_op(out_alu_op), .out_lane(out_lane),
    .out_last(out_last), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // ctl = {reg_write, vector_write, mem_read, mem_write, branch, jump, alu_src_imm, is_vector}
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] imm;
    logic [7:0]  ctl;
    logic [3:0]  alu;
    logic        ill;
  } vec_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [3:0]  opcode;
    logic [2:0]  rd, rs1, rs2, func;
    logic [15:0] imm;
    logic [7:0]  ctl;
    logic [3:0]  alu;
    logic        ill;
    logic [1:0]  lane;
    logic        last;
    logic        rdy;
  } exp_t;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic        mon_en = 1'b0;
  exp_t        sb[$];
  vec_t        tbl[12];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input vec_t v);
    exp_t e;
    int unsigned n;
    n = (v.instr[15:12] == 4'hB) ? 4 : 1;
    for (int unsigned l = 0; l < n; l++) begin
      e.pc = v.pc; e.opcode = v.instr[15:12];
      e.rd = v.instr[11:9]; e.rs1 = v.instr[8:6]; e.rs2 = v.instr[5:3]; e.func = v.instr[2:0];
      e.imm = v.imm; e.ctl = v.ctl; e.alu = v.alu; e.ill = v.ill;
      e.lane = 2'(l);
      e.last = (l == n - 1);
      e.rdy  = (l == n - 1);
      sb.push_back(e);
    end
  endtask

  // Offer v until accepted; entered and left just after a rising edge.
  task automatic drive(input vec_t v);
    int unsigned n;
    logic rdy;
    n = 0;
    in_valid = 1'b1; in_instr = v.instr; in_pc = v.pc;
    do begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); n++;
    end while (!rdy && n < 50);
    if (rdy) push(v);
    else begin
      tests++; fails++;
      $display("FAIL accept_timeout: instr %h never accepted", v.instr);
    end
    #1;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
    #1;
    check("drain", 80'(sb.size()), 80'd0);
  endtask

  always @(negedge clk) begin
    exp_t a;
    if (mon_en && rst_n && out_valid && out_ready) begin
      a = {out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_func, out_imm,
           {out_reg_write, out_vector_write, out_mem_read, out_mem_write,
            out_branch, out_jump, out_alu_src_imm, out_is_vector},
           out_alu_op, out_illegal, out_lane, out_last, in_ready};
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_uop: got %h expected nothing", a);
      end else begin
        check("uop", 80'(a), 80'(sb.pop_front()));
      end
    end
  end

  initial begin
    tbl[0]  = '{16'h1A3F, 16'h0100, 16'hFFFF, 8'h82, 4'h0, 1'b0};
    tbl[1]  = '{16'h0A4D, 16'h0102, 16'h0000, 8'h80, 4'h5, 1'b0};
    tbl[2]  = '{16'h7285, 16'h0104, 16'h0005, 8'hA2, 4'h0, 1'b0};
    tbl[3]  = '{16'h8A45, 16'h0106, 16'h0005, 8'h12, 4'h0, 1'b0};
    tbl[4]  = '{16'h9120, 16'h0108, 16'hFF20, 8'h08, 4'h1, 1'b0};
    tbl[5]  = '{16'hA800, 16'h010A, 16'hF800, 8'h04, 4'h0, 1'b0};
    tbl[6]  = '{16'hB123, 16'h010C, 16'h0000, 8'h41, 4'h0, 1'b0};
    tbl[7]  = '{16'hA7FF, 16'h010E, 16'h07FF, 8'h04, 4'h0, 1'b0};
    tbl[8]  = '{16'hC000, 16'h0110, 16'h0000, 8'h00, 4'h0, 1'b1};
    tbl[9]  = '{16'h1020, 16'h0112, 16'hFFE0, 8'h82, 4'h0, 1'b0};
    tbl[10] = '{16'hF123, 16'h0114, 16'h0000, 8'h00, 4'h0, 1'b1};
    tbl[11] = '{16'h0001, 16'h0116, 16'h0000, 8'h80, 4'h1, 1'b0};

    // Reset state
    #2;
    check("reset_outputs",
          80'({in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_func,
               out_imm, out_reg_write, out_vector_write, out_mem_read, out_mem_write,
               out_branch, out_jump, out_alu_src_imm, out_is_vector, out_alu_op,
               out_lane, out_last, out_illegal}), 80'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("post_reset_ready_valid", 80'({in_ready, out_valid}), 80'b10);

    // Streamed table with full downstream readiness
    @(posedge clk); #1;
    mon_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) drive(tbl[i]);
    in_valid = 1'b0;
    drain();

    // Stall while holding STB
    out_ready = 1'b0;
    drive(tbl[3]);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold",
            80'({out_valid, in_ready, out_mem_write, out_alu_src_imm, out_imm, out_pc, out_lane}),
            80'({1'b1, 1'b0, 1'b1, 1'b1, 16'h0005, 16'h0106, 2'd0}));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // Flush during lane 1 of a vector, with a competing instruction offered
    mon_en = 1'b0;
    in_valid = 1'b1; in_instr = 16'hB123; in_pc = 16'h0200;
    @(negedge clk) check("flush_pre_ready", 80'(in_ready), 80'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_instr = 16'h1A3F; in_pc = 16'h0204;
    @(negedge clk) check("flush_mid_vector", 80'({out_valid, out_lane, in_ready}), 80'({1'b1, 2'd1, 1'b0}));
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk) check("flush_result", 80'({out_valid, out_lane, out_pc, out_is_vector}), 80'd0);
    @(posedge clk);
    @(negedge clk) check("flush_no_accept", 80'({out_valid, out_reg_write}), 80'd0);

    // Asynchronous reset mid-expansion
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = 16'hB123; in_pc = 16'h0300;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_lane", 80'({out_valid, out_lane}), 80'({1'b1, 2'd1}));
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid_vector",
             80'({out_valid, out_lane, out_is_vector, out_vector_write, out_last, in_ready, out_pc}), 80'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 check("after_reset_idle", 80'({out_valid, in_ready}), 80'b01);

    // Scalar after recovery goes through the scoreboard again
    mon_en = 1'b1;
    drive(tbl[5]);
    in_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
